ifetch_buffer: RTL and testbench



---
 rtl/ifetch_buffer.sv | 131 +++++++++++++
 tb/tb_ifetch_buffer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_buffer.sv
// Instruction fetch front-end: single-outstanding imem requests, a DEPTH-entry
// {pc,instr} FIFO toward decode, and redirect-driven flush/discard.
module ifetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [31:0]            imem_rdata,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic                   instr_valid,
  output logic [31:0]            instr,
  output logic [31:0]            instr_pc,
  input  logic                   instr_ready,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        req_pc_q, req_pc_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        pc_mem_q  [DEPTH];
  logic [31:0]        pc_mem_d  [DEPTH];
  logic [31:0]        ins_mem_q [DEPTH];
  logic [31:0]        ins_mem_d [DEPTH];
  logic               accept, push, pop;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state; redirect outranks every other event in its cycle
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      case (state_q)
        WAIT:    state_d = imem_rvalid ? IDLE : DROP;
        DROP:    state_d = DROP;
        default: state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE:       if (accept)      state_d = WAIT;
        WAIT, DROP: if (imem_rvalid) state_d = IDLE;
        default:    state_d = IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    imem_req  = (state_q == IDLE) && (count_q < CNT_W'(DEPTH)) && !redirect && !rst;
    imem_addr = fetch_pc_q;
  end

  always_comb begin
    accept      = imem_req && imem_gnt;
    push        = (state_q == WAIT) && imem_rvalid && !redirect;
    instr_valid = (count_q != '0);
    pop         = instr_valid && instr_ready && !redirect;
    instr       = ins_mem_q[rd_ptr_q];
    instr_pc    = pc_mem_q[rd_ptr_q];
    fifo_count  = count_q;

    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pc_mem_d   = pc_mem_q;
    ins_mem_d  = ins_mem_q;

    if (redirect) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (accept) begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (push) begin
        pc_mem_d[wr_ptr_q]  = req_pc_q;
        ins_mem_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage contents need no reset; count gates visibility
  always_ff @(posedge clk) begin
    pc_mem_q  <= pc_mem_d;
    ins_mem_q <= ins_mem_d;
  end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Bench for ifetch_buffer: directed scenarios plus randomized traffic against a
// queue-based reference model with a variable-latency memory responder.
module tb_ifetch_buffer;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned CW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_gnt = 1'b0;
  logic          imem_rvalid = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          instr_valid;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic          instr_ready = 1'b0;
  logic [CW-1:0] fifo_count;

  int nchk = 0;
  int nerr = 0;

  ifetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Reference model: fetched-word queue plus "one request in flight / to be dropped"
  logic [63:0]  m_q[$];
  logic [31:0]  m_fetch  = RESET_PC;
  logic [31:0]  m_req_pc = '0;
  bit           m_out    = 1'b0;
  bit           m_disc   = 1'b0;

  // Memory responder
  bit           r_pend = 1'b0;
  logic [31:0]  r_addr = '0;
  int unsigned  r_lat  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit m_req();
    return !rst && !m_out && (m_q.size() < DEPTH) && !redirect;
  endfunction

  // Drive inputs just after the falling edge, let outputs settle
  task automatic drive(input bit g, input bit rdy, input bit rd, input logic [31:0] rpc);
    imem_gnt    = g;
    instr_ready = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    imem_rvalid = r_pend && (r_lat == 0);
    imem_rdata  = imem_rvalid ? mem_word(r_addr) : $urandom;
    #1;
  endtask

  // Advance model and responder across the next rising edge
  task automatic adv(input int unsigned lat);
    bit hs;
    bit mr;
    hs = imem_req && imem_gnt;
    mr = m_req();
    if (rst) begin
      m_q.delete();
      m_fetch = RESET_PC;
      m_out   = 1'b0;
      m_disc  = 1'b0;
    end else if (redirect) begin
      m_q.delete();
      m_fetch = {redirect_pc[31:2], 2'b00};
      if (m_out) begin
        if (!m_disc && imem_rvalid) m_out = 1'b0;
        else                        m_disc = 1'b1;
      end
    end else begin
      if (m_q.size() != 0 && instr_ready) void'(m_q.pop_front());
      if (m_out && imem_rvalid) begin
        if (!m_disc) m_q.push_back({m_req_pc, imem_rdata});
        m_out  = 1'b0;
        m_disc = 1'b0;
      end
      if (mr && imem_gnt) begin
        m_out    = 1'b1;
        m_req_pc = m_fetch;
        m_fetch  = m_fetch + 32'd4;
      end
    end
    if (imem_rvalid) r_pend = 1'b0;
    if (hs) begin
      r_pend = 1'b1;
      r_addr = imem_addr;
      r_lat  = lat;
    end else if (r_pend && r_lat > 0) begin
      r_lat = r_lat - 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    r_pend = 1'b0;
    rst = 1'b1;
    drive(0, 0, 0, '0); adv(0);
    drive(0, 0, 0, '0); adv(0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    r_pend = 1'b0;
    rst = 1'b1;
    drive(1, 1, 0, '0);
    nchk++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL reset_req_low: imem_req=%b required 0", imem_req); end
    adv(0);
    drive(1, 1, 0, '0);
    adv(0);
    rst = 1'b0;
    drive(0, 0, 0, '0);
    nchk++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: instr_valid=%b required 0", instr_valid); end
    nchk++; if (fifo_count !== '0) begin nerr++; $display("FAIL reset_count: fifo_count=%0d required 0", fifo_count); end
    nchk++; if (imem_req !== 1'b1) begin nerr++; $display("FAIL reset_first_req: imem_req=%b required 1", imem_req); end
    nchk++; if (imem_addr !== RESET_PC) begin nerr++; $display("FAIL reset_addr: imem_addr=%h required %h", imem_addr, RESET_PC); end
    adv(0);
  endtask

  task automatic test_basic();
    logic [31:0] iss[$];
    logic [63:0] got[$];
    logic [31:0] exp_pc;
    bit prev_rv;
    prev_rv = 1'b0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1, 1, 0, '0);
      if (imem_req && imem_gnt) iss.push_back(imem_addr);
      nchk++;
      if (instr_valid !== prev_rv) begin
        nerr++; $display("FAIL basic_latency: cycle %0d instr_valid=%b required %b", i, instr_valid, prev_rv);
      end
      if (instr_valid) got.push_back({instr_pc, instr});
      prev_rv = imem_rvalid;
      adv(0);
    end
    nchk++; if (iss.size() < 4) begin nerr++; $display("FAIL basic_issue_count: issued=%0d required >=4", iss.size()); end
    for (int i = 0; i < 4 && i < iss.size(); i++) begin
      exp_pc = 32'(4 * i);
      nchk++; if (iss[i] !== exp_pc) begin nerr++; $display("FAIL basic_issue_addr: #%0d addr=%h required %h", i, iss[i], exp_pc); end
    end
    nchk++; if (got.size() < 3) begin nerr++; $display("FAIL basic_deliver_count: delivered=%0d required >=3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      exp_pc = 32'(4 * i);
      nchk++;
      if (got[i] !== {exp_pc, mem_word(exp_pc)}) begin
        nerr++; $display("FAIL basic_deliver: #%0d pc/instr=%h required %h", i, got[i], {exp_pc, mem_word(exp_pc)});
      end
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive(1, 0, 0, '0);
      if (i >= 10) begin
        nchk++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL full_req: cycle %0d imem_req=%b required 0", i, imem_req); end
      end
      adv(0);
    end
    drive(1, 1, 0, '0);
    nchk++; if (fifo_count !== CW'(4)) begin nerr++; $display("FAIL full_count: fifo_count=%0d required 4", fifo_count); end
    nchk++; if (instr_pc !== 32'h0) begin nerr++; $display("FAIL full_head_pc: instr_pc=%h required 0", instr_pc); end
    nchk++; if (instr !== mem_word(32'h0)) begin nerr++; $display("FAIL full_head_instr: instr=%h required %h", instr, mem_word(32'h0)); end
    adv(0);
    drive(1, 0, 0, '0);
    nchk++; if (fifo_count !== CW'(3)) begin nerr++; $display("FAIL full_pop_count: fifo_count=%0d required 3", fifo_count); end
    nchk++; if (imem_req !== 1'b1) begin nerr++; $display("FAIL full_pop_req: imem_req=%b required 1", imem_req); end
    nchk++; if (imem_addr !== 32'h10) begin nerr++; $display("FAIL full_pop_addr: imem_addr=%h required 00000010", imem_addr); end
    adv(0);
  endtask

  task automatic test_redirect_wait();
    bit seen;
    seen = 1'b0;
    do_reset();
    drive(1, 0, 0, '0); adv(3);
    drive(0, 0, 1, 32'h0000_0103); adv(0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, '0);
      nchk++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL drop_req: cycle %0d imem_req=%b required 0", i, imem_req); end
      adv(0);
    end
    drive(0, 0, 0, '0);
    nchk++; if (fifo_count !== '0) begin nerr++; $display("FAIL drop_count: fifo_count=%0d required 0", fifo_count); end
    nchk++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL drop_valid: instr_valid=%b required 0", instr_valid); end
    nchk++; if (imem_req !== 1'b1) begin nerr++; $display("FAIL drop_resume_req: imem_req=%b required 1", imem_req); end
    nchk++; if (imem_addr !== 32'h100) begin nerr++; $display("FAIL drop_resume_addr: imem_addr=%h required 00000100", imem_addr); end
    adv(0);
    for (int i = 0; i < 10 && !seen; i++) begin
      drive(1, 1, 0, '0);
      if (instr_valid) begin
        seen = 1'b1;
        nchk++; if (instr_pc !== 32'h100) begin nerr++; $display("FAIL drop_first_pc: instr_pc=%h required 00000100", instr_pc); end
        nchk++; if (instr !== mem_word(32'h100)) begin nerr++; $display("FAIL drop_first_instr: instr=%h required %h", instr, mem_word(32'h100)); end
      end
      adv(0);
    end
    nchk++; if (!seen) begin nerr++; $display("FAIL drop_timeout: delivered=0 required 1 within 10 cycles"); end
  endtask

  task automatic test_redirect_collide();
    do_reset();
    for (int i = 0; i < 5; i++) begin drive(1, 0, 0, '0); adv(0); end
    drive(1, 1, 1, 32'h0000_0200);
    nchk++; if (fifo_count !== CW'(2)) begin nerr++; $display("FAIL collide_pre_count: fifo_count=%0d required 2", fifo_count); end
    nchk++; if (instr_valid !== 1'b1) begin nerr++; $display("FAIL collide_pre_valid: instr_valid=%b required 1", instr_valid); end
    adv(0);
    drive(0, 0, 0, '0);
    nchk++; if (fifo_count !== '0) begin nerr++; $display("FAIL collide_count: fifo_count=%0d required 0", fifo_count); end
    nchk++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL collide_valid: instr_valid=%b required 0", instr_valid); end
    nchk++; if (imem_req !== 1'b1) begin nerr++; $display("FAIL collide_req: imem_req=%b required 1", imem_req); end
    nchk++; if (imem_addr !== 32'h200) begin nerr++; $display("FAIL collide_addr: imem_addr=%h required 00000200", imem_addr); end
    adv(0);
  endtask

  task automatic test_wrap();
    logic [31:0] pcs[$];
    logic [31:0] exp_pc;
    do_reset();
    drive(0, 0, 1, 32'hFFFF_FFF8); adv(0);
    for (int i = 0; i < 14 && pcs.size() < 3; i++) begin
      drive(1, 1, 0, '0);
      if (instr_valid) begin
        pcs.push_back(instr_pc);
        nchk++; if (instr !== mem_word(instr_pc)) begin nerr++; $display("FAIL wrap_instr: pc=%h instr=%h required %h", instr_pc, instr, mem_word(instr_pc)); end
      end
      adv(0);
    end
    nchk++; if (pcs.size() != 3) begin nerr++; $display("FAIL wrap_count: delivered=%0d required 3", pcs.size()); end
    for (int i = 0; i < pcs.size(); i++) begin
      exp_pc = 32'hFFFF_FFF8 + 32'(4 * i);
      nchk++; if (pcs[i] !== exp_pc) begin nerr++; $display("FAIL wrap_pc: #%0d pc=%h required %h", i, pcs[i], exp_pc); end
    end
  endtask

  task automatic test_stall_and_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, '0);
      nchk++; if (imem_req !== 1'b1) begin nerr++; $display("FAIL stall_req: cycle %0d imem_req=%b required 1", i, imem_req); end
      nchk++; if (imem_addr !== RESET_PC) begin nerr++; $display("FAIL stall_addr: cycle %0d imem_addr=%h required %h", i, imem_addr, RESET_PC); end
      adv(0);
    end
    drive(1, 0, 0, '0); adv(4);
    rst = 1'b1;
    drive(0, 0, 0, '0);
    nchk++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL midrst_req: imem_req=%b required 0", imem_req); end
    adv(0);
    rst = 1'b0;
    drive(0, 0, 0, '0);
    nchk++; if (fifo_count !== '0) begin nerr++; $display("FAIL midrst_count: fifo_count=%0d required 0", fifo_count); end
    nchk++; if (imem_addr !== RESET_PC) begin nerr++; $display("FAIL midrst_addr: imem_addr=%h required %h", imem_addr, RESET_PC); end
    nchk++; if (imem_req !== 1'b1) begin nerr++; $display("FAIL midrst_req_after: imem_req=%b required 1", imem_req); end
    adv(0);
    for (int i = 0; i < 6; i++) begin drive(0, 0, 0, '0); adv(0); end
    drive(0, 0, 0, '0);
    nchk++; if (fifo_count !== '0) begin nerr++; $display("FAIL late_rvalid_count: fifo_count=%0d required 0", fifo_count); end
    nchk++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL late_rvalid_valid: instr_valid=%b required 0", instr_valid); end
    nchk++; if (imem_req !== 1'b1) begin nerr++; $display("FAIL late_rvalid_req: imem_req=%b required 1", imem_req); end
    adv(0);
  endtask

  task automatic test_random();
    bit g, rdy, rd, rv_next;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst     = ($urandom_range(0, 399) == 0);
      g       = ($urandom_range(0, 9) < 7);
      rdy     = ($urandom_range(0, 9) < 6);
      rv_next = r_pend && (r_lat == 0);
      rd      = ($urandom_range(0, 29) == 0) && !(rv_next && m_out && m_disc);
      drive(g, rdy, rd, $urandom);
      nchk++; if (imem_req !== m_req()) begin nerr++; $display("FAIL rand_req: cycle %0d imem_req=%b required %b", i, imem_req, m_req()); end
      if (m_req()) begin
        nchk++; if (imem_addr !== m_fetch) begin nerr++; $display("FAIL rand_addr: cycle %0d imem_addr=%h required %h", i, imem_addr, m_fetch); end
      end
      if (!rst) begin
        nchk++; if (fifo_count !== CW'(m_q.size())) begin nerr++; $display("FAIL rand_count: cycle %0d fifo_count=%0d required %0d", i, fifo_count, m_q.size()); end
        nchk++; if (instr_valid !== (m_q.size() != 0)) begin nerr++; $display("FAIL rand_valid: cycle %0d instr_valid=%b required %b", i, instr_valid, m_q.size() != 0); end
        if (m_q.size() != 0) begin
          nchk++; if ({instr_pc, instr} !== m_q[0]) begin nerr++; $display("FAIL rand_head: cycle %0d pc/instr=%h required %h", i, {instr_pc, instr}, m_q[0]); end
        end
      end
      adv($urandom_range(0, 3));
    end
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_full();
    test_redirect_wait();
    test_redirect_collide();
    test_wrap();
    test_stall_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
